mem_ctrl: RTL and testbench

Byte-serial memory controller between the CPU core and the 8-bit unified RAM/IO port. Arbitrates the instruction-fetch port and the load/store buffer port, sequences each access as 1/2/4 single-byte RAM cycles, and returns assembled, sign/zero-extended data with a one-cycle ready pulse. Honours the IO back-pressure signal for IO-mapped stores and aborts speculative work on pipeline flush.

---
 rtl/mem_ctrl_pkg.sv | 34 +++
 rtl/mem_ctrl_if.sv | 25 ++
 rtl/mem_load_extend.sv | 22 ++
 rtl/mem_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_mem_ctrl.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the byte-serial memory controller: state encoding,
// lsb_op field positions, access size codes and default IO addresses.
package mem_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_STORE,
        S_DONE
    } state_t;

    // lsb_op fields
    localparam int OP_STORE_BIT    = 3;
    localparam int OP_UNSIGNED_BIT = 2;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    localparam logic [31:0] IO_ADDR_LO_DEFAULT = 32'h0003_0000;
    localparam logic [31:0] IO_ADDR_HI_DEFAULT = 32'h0003_0004;

    // Number of single-byte RAM cycles for a size code; the unused code
    // behaves like a word so a stray encoding can never hang the sequencer.
    function automatic logic [2:0] size_len(input logic [1:0] size);
        case (size)
            SIZE_BYTE: size_len = 3'd1;
            SIZE_HALF: size_len = 3'd2;
            default:   size_len = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Core-side request/response bundle: instruction-fetch port and load/store
// buffer port. The core is the master, the controller the slave.
interface mem_ctrl_if;
    logic        if_valid;
    logic [31:0] if_addr;
    logic        if_ready;
    logic [31:0] if_data;

    logic        lsb_valid;
    logic [31:0] lsb_addr;
    logic [31:0] lsb_data;
    logic [3:0]  lsb_op;
    logic        lsb_ready;
    logic [31:0] lsb_val;

    modport master (
        output if_valid, if_addr, lsb_valid, lsb_addr, lsb_data, lsb_op,
        input  if_ready, if_data, lsb_ready, lsb_val
    );

    modport slave (
        input  if_valid, if_addr, lsb_valid, lsb_addr, lsb_data, lsb_op,
        output if_ready, if_data, lsb_ready, lsb_val
    );
endinterface

// File: rtl/mem_load_extend.sv
// Combinational load result formatting: byte/half are sign- or
// zero-extended from their top bit, words pass through unchanged.
module mem_load_extend
    import mem_ctrl_pkg::*;
(
    input  logic [31:0] raw,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] ext
);

    // Select the extension by access size.
    always_comb begin
        ext = raw;
        case (size)
            SIZE_BYTE: ext = {{24{raw[7]  & ~is_unsigned}}, raw[7:0]};
            SIZE_HALF: ext = {{16{raw[15] & ~is_unsigned}}, raw[15:0]};
            default:   ext = raw;
        endcase
    end

endmodule

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller. Arbitrates fetch and load/store requests
// (load/store wins), runs each access as 1/2/4 single-byte RAM cycles and
// returns assembled data with a one-cycle ready pulse. RAM reads are
// synchronous: the byte for mem_a appears on mem_din one cycle later.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter logic [31:0] IO_ADDR_LO = IO_ADDR_LO_DEFAULT,
    parameter logic [31:0] IO_ADDR_HI = IO_ADDR_HI_DEFAULT
) (
    input  logic        clk_in,
    input  logic        rst_n,
    input  logic        rdy_in,
    input  logic        clear_flag,
    mem_ctrl_if.slave   core,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full
);

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [2:0]  len_q, len_d;
    logic [31:0] base_q, base_d;
    logic [31:0] data_q, data_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic        fetch_q, fetch_d;
    logic        flushed_q, flushed_d;
    logic [31:0] buf_q, buf_d;
    logic [31:0] mem_a_q, mem_a_d;
    logic [7:0]  dout_q, dout_d;
    logic        wr_q, wr_d;
    logic [31:0] if_data_q, if_data_d;
    logic [31:0] lsb_val_q, lsb_val_d;

    logic [1:0]  lane_idx;
    logic [31:0] buf_merged;
    logic [31:0] ext_val;
    logic        io_hit;
    logic        done_pulse;

    // In a read state with cnt = c, mem_din carries byte c-1.
    assign lane_idx = 2'(cnt_q - 3'd1);
    assign io_hit   = (base_q == IO_ADDR_LO) || (base_q == IO_ADDR_HI);

    // Read buffer with the byte currently on mem_din merged into its lane, so
    // the last byte reaches the result in the same cycle it is captured.
    always_comb begin
        buf_merged = buf_q;
        buf_merged[{lane_idx, 3'b000} +: 8] = mem_din;
    end

    mem_load_extend u_extend (
        .raw         (buf_merged),
        .size        (size_q),
        .is_unsigned (uns_q),
        .ext         (ext_val)
    );

    // Next-state and datapath update for the access sequencer.
    always_comb begin
        // NOTE: every target gets its hold value first, so no path through the case can infer a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        len_d     = len_q;
        base_d    = base_q;
        data_d    = data_q;
        size_d    = size_q;
        uns_d     = uns_q;
        fetch_d   = fetch_q;
        flushed_d = flushed_q;
        buf_d     = buf_q;
        mem_a_d   = mem_a_q;
        dout_d    = dout_q;
        wr_d      = 1'b0;
        if_data_d = if_data_q;
        lsb_val_d = lsb_val_q;

        case (state_q)
            S_IDLE: begin
                flushed_d = 1'b0;
                cnt_d     = 3'd0;
                buf_d     = '0;
                if (!clear_flag) begin
                    if (core.lsb_valid) begin
                        base_d  = core.lsb_addr;
                        data_d  = core.lsb_data;
                        size_d  = core.lsb_op[1:0];
                        uns_d   = core.lsb_op[OP_UNSIGNED_BIT];
                        len_d   = size_len(core.lsb_op[1:0]);
                        fetch_d = 1'b0;
                        mem_a_d = core.lsb_addr;
                        state_d = core.lsb_op[OP_STORE_BIT] ? S_STORE : S_LOAD;
                    end else if (core.if_valid) begin
                        base_d  = core.if_addr;
                        size_d  = SIZE_WORD;
                        uns_d   = 1'b1;
                        len_d   = 3'd4;
                        fetch_d = 1'b1;
                        mem_a_d = core.if_addr;
                        state_d = S_FETCH;
                    end
                end
            end

            S_FETCH, S_LOAD: begin
                if (clear_flag) begin
                    state_d = S_IDLE;
                end else begin
                    if (cnt_q != 3'd0) begin
                        buf_d = buf_merged;
                    end
                    if (cnt_q == len_q) begin
                        state_d = S_DONE;
                        if (fetch_q) begin
                            if_data_d = buf_merged;
                        end else begin
                            lsb_val_d = ext_val;
                        end
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                        if (cnt_d < len_q) begin
                            mem_a_d = base_q + {29'd0, cnt_d};
                        end
                    end
                end
            end

            S_STORE: begin
                // A store is committed once accepted; a flush only mutes its ready.
                flushed_d = flushed_q | clear_flag;
                if (cnt_q == len_q) begin
                    state_d   = S_DONE;
                    lsb_val_d = '0;
                end else if (!(io_hit && io_buffer_full)) begin
                    mem_a_d = base_q + {29'd0, cnt_q};
                    dout_d  = data_q[{cnt_q[1:0], 3'b000} +: 8];
                    wr_d    = 1'b1;
                    cnt_d   = cnt_q + 3'd1;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; rdy_in low freezes everything.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            len_q     <= '0;
            base_q    <= '0;
            data_q    <= '0;
            size_q    <= SIZE_BYTE;
            uns_q     <= 1'b0;
            fetch_q   <= 1'b0;
            flushed_q <= 1'b0;
            buf_q     <= '0;
            mem_a_q   <= '0;
            dout_q    <= '0;
            wr_q      <= 1'b0;
            if_data_q <= '0;
            lsb_val_q <= '0;
        end else if (rdy_in) begin
            // NOTE: non-blocking so every register samples the pre-edge values computed above.
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            len_q     <= len_d;
            base_q    <= base_d;
            data_q    <= data_d;
            size_q    <= size_d;
            uns_q     <= uns_d;
            fetch_q   <= fetch_d;
            flushed_q <= flushed_d;
            buf_q     <= buf_d;
            mem_a_q   <= mem_a_d;
            dout_q    <= dout_d;
            wr_q      <= wr_d;
            if_data_q <= if_data_d;
            lsb_val_q <= lsb_val_d;
        end
    end

    // DONE lasts until rdy_in lets it advance, so gating with rdy_in keeps it to one pulse.
    assign done_pulse = (state_q == S_DONE) && rdy_in && !flushed_q && !clear_flag;

    assign core.if_ready  = done_pulse &&  fetch_q;
    assign core.lsb_ready = done_pulse && !fetch_q;
    assign core.if_data   = if_data_q;
    assign core.lsb_val   = lsb_val_q;

    assign mem_a    = mem_a_q;
    assign mem_dout = dout_q;
    assign mem_wr   = wr_q && rdy_in;

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: synchronous byte RAM model, a request
// driver, and a queue scoreboard of expected results popped at each ready.
module tb_mem_ctrl;
    logic        clk_in;
    logic        rst_n;
    logic        rdy_in;
    logic        clear_flag;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full;

    mem_ctrl_if core_if ();

    mem_ctrl dut (
        .clk_in         (clk_in),
        .rst_n          (rst_n),
        .rdy_in         (rdy_in),
        .clear_flag     (clear_flag),
        .core           (core_if),
        .mem_din        (mem_din),
        .mem_dout       (mem_dout),
        .mem_a          (mem_a),
        .mem_wr         (mem_wr),
        .io_buffer_full (io_buffer_full)
    );

    int errors = 0;
    int checks = 0;

    logic [7:0]  ram [logic [31:0]];
    logic [31:0] exp_q [$];
    logic [31:0] wr_a_q [$];
    logic [7:0]  wr_d_q [$];
    int          wr_n_q [$];
    logic [31:0] a_log [$];
    int          frozen_wr;
    int          stray_ready;

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Synchronous RAM: write on mem_wr, read data for mem_a one cycle later.
    always @(posedge clk_in) begin
        if (mem_wr) ram[mem_a] = mem_dout;
        mem_din <= ram.exists(mem_a) ? ram[mem_a] : 8'h00;
    end

    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        return ram.exists(a) ? ram[a] : 8'h00;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Drives one request and watches up to max_n edges after acceptance edge (n=0).
    task automatic run_access(input logic is_fetch, input logic [31:0] addr,
                              input logic [31:0] data, input logic [3:0] op,
                              input int clear_at, input int freeze_at, input int freeze_len,
                              input int full_len, input int max_n,
                              output int ready_n, output logic [31:0] val);
        wr_a_q.delete(); wr_d_q.delete(); wr_n_q.delete(); a_log.delete();
        frozen_wr = 0; stray_ready = 0; ready_n = -1; val = '0;
        @(posedge clk_in); #1;
        io_buffer_full = (full_len > 0);
        if (is_fetch) begin
            core_if.if_valid = 1'b1; core_if.if_addr = addr;
        end else begin
            core_if.lsb_valid = 1'b1; core_if.lsb_addr = addr;
            core_if.lsb_data = data; core_if.lsb_op = op;
        end
        for (int n = 0; n <= max_n; n++) begin
            @(posedge clk_in); #1;
            a_log.push_back(mem_a);
            if (mem_wr) begin
                wr_a_q.push_back(mem_a); wr_d_q.push_back(mem_dout); wr_n_q.push_back(n);
            end
            if (!rdy_in && mem_wr) frozen_wr++;
            if (is_fetch ? core_if.lsb_ready : core_if.if_ready) stray_ready++;
            if (is_fetch ? core_if.if_ready : core_if.lsb_ready) begin
                ready_n = n;
                val = is_fetch ? core_if.if_data : core_if.lsb_val;
                break;
            end
            if (n == clear_at) begin
                clear_flag = 1'b1; core_if.if_valid = 1'b0; core_if.lsb_valid = 1'b0;
            end else begin
                clear_flag = 1'b0;
            end
            if (n == freeze_at) rdy_in = 1'b0;
            if (n == freeze_at + freeze_len) rdy_in = 1'b1;
            if (n == full_len) io_buffer_full = 1'b0;
        end
        core_if.if_valid = 1'b0; core_if.lsb_valid = 1'b0;
        clear_flag = 1'b0; rdy_in = 1'b1; io_buffer_full = 1'b0;
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk_in);
        #1;
        checks++; if (mem_a !== 32'h0) begin errors++; $display("FAIL reset_mem_a: got %h want 0", mem_a); end
        checks++; if (mem_dout !== 8'h0) begin errors++; $display("FAIL reset_mem_dout: got %h want 0", mem_dout); end
        checks++; if (mem_wr !== 1'b0) begin errors++; $display("FAIL reset_mem_wr: got %b want 0", mem_wr); end
        checks++; if ({core_if.if_ready, core_if.lsb_ready} !== 2'b00) begin
            errors++; $display("FAIL reset_ready: got %b want 00", {core_if.if_ready, core_if.lsb_ready}); end
        checks++; if (core_if.if_data !== 32'h0) begin errors++; $display("FAIL reset_if_data: got %h want 0", core_if.if_data); end
        checks++; if (core_if.lsb_val !== 32'h0) begin errors++; $display("FAIL reset_lsb_val: got %h want 0", core_if.lsb_val); end
        @(negedge clk_in) rst_n = 1'b1;
    endtask

    task automatic test_load_word;
        int rn; logic [31:0] v, e;
        ram[32'h100] = 8'h11; ram[32'h101] = 8'h22; ram[32'h102] = 8'h33; ram[32'h103] = 8'h44;
        exp_q.push_back(32'h4433_2211);
        run_access(1'b0, 32'h100, 32'h0, 4'b0010, -1, -1, 0, 0, 20, rn, v);
        checks++; if (rn !== 5) begin errors++; $display("FAIL lw_ready_cycle: got %0d want 5", rn); end
        e = exp_q.pop_front();
        checks++; if (v !== e) begin errors++; $display("FAIL lw_value: got %h want %h", v, e); end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (a_log.size() <= k || a_log[k] !== 32'h100 + k) begin
                errors++; $display("FAIL lw_mem_a[%0d]: got %h want %h", k, (a_log.size() > k) ? a_log[k] : 32'hx, 32'h100 + k);
            end
        end
    endtask

    task automatic test_load_extend;
        int rn; logic [31:0] v, e;
        logic [31:0] addrs [4] = '{32'h200, 32'h200, 32'h202, 32'h202};
        logic [3:0]  ops   [4] = '{4'b0000, 4'b0100, 4'b0001, 4'b0101};
        int          lat   [4] = '{2, 2, 3, 3};
        ram[32'h200] = 8'h80; ram[32'h202] = 8'h01; ram[32'h203] = 8'h80;
        exp_q.push_back(32'hFFFF_FF80); exp_q.push_back(32'h0000_0080);
        exp_q.push_back(32'hFFFF_8001); exp_q.push_back(32'h0000_8001);
        for (int i = 0; i < 4; i++) begin
            run_access(1'b0, addrs[i], 32'h0, ops[i], -1, -1, 0, 0, 20, rn, v);
            e = exp_q.pop_front();
            checks++; if (v !== e) begin errors++; $display("FAIL ext_value op=%b: got %h want %h", ops[i], v, e); end
            checks++; if (rn !== lat[i]) begin errors++; $display("FAIL ext_ready_cycle op=%b: got %0d want %0d", ops[i], rn, lat[i]); end
        end
    endtask

    task automatic test_store_half;
        int rn; logic [31:0] v, e;
        exp_q.push_back(32'h0);
        run_access(1'b0, 32'h10, 32'hAABB_CCDD, 4'b1001, -1, -1, 0, 0, 20, rn, v);
        checks++; if (rn !== 3) begin errors++; $display("FAIL sh_ready_cycle: got %0d want 3", rn); end
        e = exp_q.pop_front();
        checks++; if (v !== e) begin errors++; $display("FAIL sh_lsb_val: got %h want %h", v, e); end
        checks++;
        if (wr_a_q.size() != 2 || wr_a_q[0] !== 32'h10 || wr_d_q[0] !== 8'hDD || wr_n_q[0] != 1
            || wr_a_q[1] !== 32'h11 || wr_d_q[1] !== 8'hCC || wr_n_q[1] != 2) begin
            errors++; $display("FAIL sh_write_cycles: got %0d writes, want DD@10 n1, CC@11 n2", wr_a_q.size());
        end
        checks++; if ({ram_rd(32'h11), ram_rd(32'h10)} !== 16'hCCDD) begin
            errors++; $display("FAIL sh_ram: got %h want ccdd", {ram_rd(32'h11), ram_rd(32'h10)}); end
    endtask

    task automatic test_priority;
        logic [31:0] e; logic seen_lsb, done;
        ram[32'h400] = 8'hDF; ram[32'h401] = 8'h9B; ram[32'h402] = 8'h57; ram[32'h403] = 8'h13;
        exp_q.push_back(32'h4433_2211);
        exp_q.push_back(32'h1357_9BDF);
        seen_lsb = 1'b0; done = 1'b0;
        @(posedge clk_in); #1;
        core_if.if_valid = 1'b1; core_if.if_addr = 32'h400;
        core_if.lsb_valid = 1'b1; core_if.lsb_addr = 32'h100; core_if.lsb_op = 4'b0010;
        for (int n = 0; n <= 40; n++) begin
            @(posedge clk_in); #1;
            if (core_if.lsb_ready) begin
                e = exp_q.pop_front();
                checks++; if (core_if.lsb_val !== e) begin errors++; $display("FAIL prio_lsb_val: got %h want %h", core_if.lsb_val, e); end
                checks++; if (n != 5) begin errors++; $display("FAIL prio_lsb_cycle: got %0d want 5", n); end
                core_if.lsb_valid = 1'b0; seen_lsb = 1'b1;
            end
            if (core_if.if_ready) begin
                checks++; if (!seen_lsb) begin errors++; $display("FAIL prio_order: got fetch first want lsb first"); end
                e = (exp_q.size() > 0) ? exp_q.pop_back() : 32'hx;
                checks++; if (core_if.if_data !== e) begin errors++; $display("FAIL prio_if_data: got %h want %h", core_if.if_data, e); end
                checks++; if (n != 12) begin errors++; $display("FAIL prio_if_cycle: got %0d want 12", n); end
                core_if.if_valid = 1'b0; done = 1'b1;
                break;
            end
        end
        core_if.if_valid = 1'b0; core_if.lsb_valid = 1'b0;
        if (!done) begin checks++; errors++; $display("FAIL prio_timeout: got no if_ready want one"); end
        exp_q.delete();
    endtask

    task automatic test_io_stall;
        int rn; logic [31:0] v;
        logic [31:0] addrs [3] = '{32'h0003_0000, 32'h0003_0004, 32'h0003_0008};
        int          full  [3] = '{5, 2, 3};
        int          lat   [3] = '{7, 4, 2};
        for (int i = 0; i < 3; i++) begin
            run_access(1'b0, addrs[i], 32'h0000_005A + i, 4'b1000, -1, -1, 0, full[i], 20, rn, v);
            checks++; if (rn !== lat[i]) begin errors++; $display("FAIL io_ready_cycle %h: got %0d want %0d", addrs[i], rn, lat[i]); end
            checks++;
            if (wr_a_q.size() != 1 || wr_a_q[0] !== addrs[i] || wr_d_q[0] !== 8'h5A + i || wr_n_q[0] != lat[i] - 1) begin
                errors++; $display("FAIL io_write %h: got %0d writes first n=%0d want 1 at n=%0d", addrs[i], wr_a_q.size(),
                                   (wr_n_q.size() > 0) ? wr_n_q[0] : -1, lat[i] - 1);
            end
        end
    endtask

    task automatic test_flush;
        int rn; logic [31:0] v, e;
        run_access(1'b1, 32'h400, 32'h0, 4'b0000, 1, -1, 0, 0, 8, rn, v);
        checks++; if (rn != -1) begin errors++; $display("FAIL flush_fetch_ready: got pulse at %0d want none", rn); end
        checks++; if (wr_a_q.size() != 0) begin errors++; $display("FAIL flush_fetch_wr: got %0d writes want 0", wr_a_q.size()); end
        exp_q.push_back(32'h4433_2211);
        run_access(1'b0, 32'h100, 32'h0, 4'b0010, -1, -1, 0, 0, 20, rn, v);
        e = exp_q.pop_front();
        checks++; if (rn !== 5 || v !== e) begin errors++; $display("FAIL flush_then_lw: got n=%0d %h want n=5 %h", rn, v, e); end
        run_access(1'b0, 32'h500, 32'hCAFE_F00D, 4'b1010, 2, -1, 0, 0, 10, rn, v);
        checks++; if (rn != -1 || stray_ready != 0) begin
            errors++; $display("FAIL flush_store_ready: got n=%0d stray=%0d want none", rn, stray_ready); end
        checks++; if (wr_a_q.size() != 4) begin errors++; $display("FAIL flush_store_count: got %0d want 4", wr_a_q.size()); end
        checks++;
        if ({ram_rd(32'h503), ram_rd(32'h502), ram_rd(32'h501), ram_rd(32'h500)} !== 32'hCAFE_F00D) begin
            errors++; $display("FAIL flush_store_ram: got %h want cafef00d",
                               {ram_rd(32'h503), ram_rd(32'h502), ram_rd(32'h501), ram_rd(32'h500)});
        end
    endtask

    task automatic test_freeze;
        int rn; logic [31:0] v;
        run_access(1'b0, 32'h600, 32'h89AB_CDEF, 4'b1010, -1, 1, 3, 0, 20, rn, v);
        checks++; if (rn !== 8) begin errors++; $display("FAIL freeze_ready_cycle: got %0d want 8", rn); end
        checks++; if (frozen_wr != 0) begin errors++; $display("FAIL freeze_mem_wr: got %0d high cycles want 0", frozen_wr); end
        checks++;
        if ({ram_rd(32'h603), ram_rd(32'h602), ram_rd(32'h601), ram_rd(32'h600)} !== 32'h89AB_CDEF) begin
            errors++; $display("FAIL freeze_ram: got %h want 89abcdef",
                               {ram_rd(32'h603), ram_rd(32'h602), ram_rd(32'h601), ram_rd(32'h600)});
        end
    endtask

    task automatic test_async_reset;
        @(posedge clk_in); #1;
        core_if.lsb_valid = 1'b1; core_if.lsb_addr = 32'h700;
        core_if.lsb_data = 32'h1234_5678; core_if.lsb_op = 4'b1010;
        repeat (2) @(posedge clk_in);
        #1;
        checks++; if (mem_wr !== 1'b1) begin errors++; $display("FAIL areset_pre_wr: got %b want 1", mem_wr); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({mem_wr, mem_a, mem_dout} !== 41'h0) begin
            errors++; $display("FAIL areset_outputs: got wr=%b a=%h d=%h want all 0", mem_wr, mem_a, mem_dout); end
        core_if.lsb_valid = 1'b0;
        @(negedge clk_in) rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; rdy_in = 1'b1; clear_flag = 1'b0; io_buffer_full = 1'b0;
        core_if.if_valid = 1'b0; core_if.if_addr = '0;
        core_if.lsb_valid = 1'b0; core_if.lsb_addr = '0; core_if.lsb_data = '0; core_if.lsb_op = '0;
        test_reset();
        test_load_word();
        test_load_extend();
        test_store_half();
        test_priority();
        test_io_stall();
        test_flush();
        test_freeze();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
